crypto_verify_seq: RTL
======================

Name: crypto_verify_seq

Overview:
Parametrised, multi-cycle, constant-time comparator for two DATA_W-bit operands. It scans the operands one CHUNK_W slice per cycle, and the cycle count never depends on the data.
- Mode 0: equality check (any-bit-differs flag).
- Mode 1: additionally computes unsigned a < b. The Ed25519 path uses this for the canonical-scalar check (s < L).
- Sits beside the signature-verify datapath and reuses one narrow compare slice in place of a 256-bit flat XOR/OR tree.

Parameters:
DATA_W, 256, operand width in bits; must be a multiple of CHUNK_W.
CHUNK_W, 32, bits compared per cycle; 8 ≤ CHUNK_W ≤ DATA_W.
NUM_CHUNKS, DATA_W/CHUNK_W, derived (localparam); number of compare cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = equality only, 1 = equality + unsigned less-than; latched at start
a  input  DATA_W  operand A, little-endian bit order (bit 0 = LSB); latched at start
b  input  DATA_W  operand B; latched at start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid from this cycle on
diff_flag  output  1  1 if a != b
lt_flag  output  1  1 if mode=1 and a < b (unsigned); always 0 when mode=0

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- On reset: state=IDLE, counter=0, busy=0, done=0, diff_flag=0, lt_flag=0. Internal operand registers and accumulators are cleared to 0.

State machine (IDLE, RUN, DONE):
- IDLE, start=1 at an edge: latch a, b and mode. Clear acc_diff=0, acc_lt=0, cnt=0. Go to RUN.
- RUN: each cycle process chunk cnt, i.e. bits [cnt*CHUNK_W +: CHUNK_W], scanning from LSB chunk to MSB chunk.
  - acc_diff |= |(a_c ^ b_c)
  - acc_lt = (a_c < b_c) | ((a_c == b_c) & acc_lt)
  - cnt increments each cycle. After processing cnt = NUM_CHUNKS-1, go to DONE.
- DONE: done=1 for exactly one cycle. Register diff_flag=acc_diff and lt_flag=acc_lt & mode_q on entry to DONE. Go to IDLE.

Latency:
- Start sampled at edge E0. RUN occupies cycles E0..E0+NUM_CHUNKS-1. done is high in the cycle after edge E0+NUM_CHUNKS.
- For the defaults this is 8 compare cycles, with done visible 9 edges after start.
- Latency is identical for all operand values and both modes. No early exit; the compare logic toggles every RUN cycle.

Result outputs:
- diff_flag and lt_flag change only on entry to DONE, on reset, or when cleared on an accepted start.
- They hold their values through IDLE until the next accepted start; the accepted start clears them to 0 at E0.

Handshake and boundary cases:
- start while busy (RUN or DONE) is ignored; no queueing.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE. Back-to-back throughput is one result per NUM_CHUNKS+2 cycles.
- Changes to a, b or mode after E0 have no effect on the running compare.
- Equal-chunk carry for lt: if all chunks are equal, lt_flag=0 and diff_flag=0.
- NUM_CHUNKS=1 is legal: RUN lasts one cycle.
- cnt width is max(1,$clog2(NUM_CHUNKS)). cnt never exceeds NUM_CHUNKS-1.
- rst_n asserted mid-RUN or in DONE aborts immediately. No done pulse is emitted and all outputs read 0 after reset.

Test Plan:
1. a=b=random 256-bit, mode=0, start pulse → done pulse exactly 9 edges after start edge; diff_flag=0, lt_flag=0; busy high for cycles 1–9.
2. a=b except bit 255 flipped (MSB chunk), then only bit 0 flipped (LSB chunk), mode=0 → diff_flag=1 both times; done cycle identical to scenario 1.
3. mode=1, b=L=0x1000000000000000000000000000000014DEF9DEA2F79CD65812631A5CF5D3ED; a=L-1 → lt_flag=1, diff_flag=1. a=L → lt_flag=0, diff_flag=0. a=L+2^252 → lt_flag=0, diff_flag=1.
4. Start asserted again during RUN with different operands, and start held high across DONE → first result unaffected; second operation begins in the IDLE cycle after DONE; 1000 random pairs all report identical start-to-done latency.
5. rst_n pulled low at compare cycle 4 → busy, done, diff_flag and lt_flag go 0 asynchronously; no done pulse; a fresh start afterwards completes normally.
6. Re-run scenarios 1–3 with DATA_W=256, CHUNK_W=8 (done 33 edges after start) and CHUNK_W=256 (done 2 edges after start) → identical flag results.

Source files
------------

// File: rtl/crypto_verify_seq.sv
// Constant-time sequential comparator: scans two DATA_W-bit operands one CHUNK_W slice
// per cycle (LSB chunk first) and reports a != b and, in mode 1, unsigned a < b.
module crypto_verify_seq #(
    parameter int DATA_W  = 256,
    parameter int CHUNK_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              diff_flag,
    output logic              lt_flag
);

    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] a_q, a_d;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] b_q, b_d;
    logic                               mode_q, mode_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               acc_diff_q, acc_diff_d;
    logic                               acc_lt_q, acc_lt_d;
    logic                               diff_flag_q, diff_flag_d;
    logic                               lt_flag_q, lt_flag_d;

    logic [CHUNK_W-1:0] a_c, b_c;
    logic               chunk_ne, chunk_lt;
    logic               diff_next, lt_next;
    logic               last_chunk;

    // NOTE: operand registers are reset along with the control state so that no
    // previous operand lingers in the flops after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            acc_diff_q  <= 1'b0;
            acc_lt_q    <= 1'b0;
            diff_flag_q <= 1'b0;
            lt_flag_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_diff_q  <= acc_diff_d;
            acc_lt_q    <= acc_lt_d;
            diff_flag_q <= diff_flag_d;
            lt_flag_q   <= lt_flag_d;
        end
    end

    assign last_chunk = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chunk select as a plain mux keeps the index width independent of NUM_CHUNKS.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_c = a_q[i];
                b_c = b_q[i];
            end
        end
    end

    assign chunk_ne  = |(a_c ^ b_c);
    assign chunk_lt  = (a_c < b_c);
    assign diff_next = acc_diff_q | chunk_ne;
    // A higher chunk decides lt outright; an equal chunk carries the lower verdict.
    assign lt_next   = chunk_lt | (~chunk_ne & acc_lt_q);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch behind.
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_diff_d  = acc_diff_q;
        acc_lt_d    = acc_lt_q;
        diff_flag_d = diff_flag_q;
        lt_flag_d   = lt_flag_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d         = a;
                    b_d         = b;
                    mode_d      = mode;
                    cnt_d       = '0;
                    acc_diff_d  = 1'b0;
                    acc_lt_d    = 1'b0;
                    diff_flag_d = 1'b0;
                    lt_flag_d   = 1'b0;
                end
            end
            RUN: begin
                acc_diff_d = diff_next;
                acc_lt_d   = lt_next;
                if (last_chunk) begin
                    cnt_d       = '0;
                    diff_flag_d = diff_next;
                    lt_flag_d   = lt_next & mode_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    assign diff_flag = diff_flag_q;
    assign lt_flag   = lt_flag_q;

endmodule
